bam8_mac_acc: RTL
=================

# bam8_mac_acc

Sequential multiply-accumulate stage that consumes operand pairs for the 8x8 unsigned broken-array approximate multiplier (horizontal break 1, vertical break 10) and accumulates the approximate products into grouped sums. It sits directly downstream of the combinational BAM multiplier. It adds a registered product stage, a saturating accumulator, a per-group term counter and valid/ready handshakes on both sides, so BAM error can be characterised on dot-product workloads.

## Interface
- ACC_W, 24, accumulator and result width; must be >= 16
- CNT_W, 8, term-counter width; a group holds at most 2^CNT_W terms
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  reset, synchronous and active-high; one clock, synchronous active-high reset
- cfg_len  input  CNT_W  terms per group; 0 is treated as 1; sampled on the first term of each group
- in_valid  input  1  operand pair valid
- in_ready  output  1  stage can accept a pair
- in_a  input  8  unsigned multiplicand
- in_b  input  8  unsigned multiplier
- out_valid  output  1  group result valid
- out_ready  input  1  downstream accepts result
- out_sum  output  ACC_W  saturated group sum
- out_ovf  output  1  group sum saturated

## Operation
- Approximate product P(a,b) = sum of a[i]·b[j]·2^(i+j) over i,j in 0..7 with i+j >= 10. Compute it exactly over the kept partial products. Bits 0..9 of P are always 0, and P fits in 16 bits.
- A pair is accepted when in_valid && in_ready.
- Stage 1 registers: s1_p = P(in_a,in_b), s1_vld, s1_last.
- Term counter cnt: 0 at reset and after each last term. It increments on every accepted pair.
- The accepted pair is last when cnt == len-1, where len = max(cfg_len,1) as latched at cnt==0. cnt then wraps to 0.
- s1_adv = !(s1_last && out_valid && !out_ready).
- in_ready = !s1_vld || s1_adv.
- When s1_vld && s1_adv:
  - Not last: acc <= sat(acc + s1_p), ovf <= ovf | carry.
  - Last: out_sum <= sat(acc + s1_p), out_ovf <= ovf | carry, out_valid <= 1, acc <= 0, ovf <= 0.
- sat(x): if x >= 2^ACC_W, the result is 2^ACC_W-1 and carry = 1.
- out_valid clears on out_valid && out_ready, unless a new result loads in the same cycle. In that case it stays 1 and out_sum/out_out_ovf take the new values.
- out_sum and out_ovf are held stable while out_valid && !out_ready.
- Non-last products keep accumulating while the output is stalled. Only a last product stalls stage 1.
- States per group: COLLECT (cnt != 0 or group open) and RESULT_PENDING (out_valid && !out_ready). Both can coexist; the next group's terms fill acc while the previous result waits.

## Timing
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_ovf=0; internal: acc=0, ovf=0, cnt=0, s1_vld=0.
- Reset mid-group discards the partial sum, any pending result and the in-flight product. Reset has priority over every other event.
- Latency: if the last pair of a group is accepted in cycle N, out_valid=1 in cycle N+2 when unstalled.
- Throughput: one pair per cycle with no stalls. Back-to-back groups of len 1 yield one result per cycle while out_ready=1.
- Stall: while a last product sits in s1 and a result is pending unaccepted, in_ready=0. in_ready returns to 1 in the cycle out_ready is seen high.
- With the defaults, a group of 2^CNT_W maximal terms (256·58368) does not saturate. Saturation is reachable only with smaller ACC_W.

## Test plan
- cfg_len=1, pair (255,255) -> out_sum=58368 two cycles after acceptance, out_ovf=0.
- cfg_len=3, pairs (255,255),(8,128),(4,128) back-to-back -> single result 59392; the (4,128) product contributes 0.
- cfg_len=0, pair (8,128) -> treated as len 1, out_sum=1024. Then cfg_len=2 with (128,8),(128,16) -> out_sum=3072.
- Backpressure: cfg_len=1, out_ready=0, stream (255,255),(8,128),(8,128).
  - First result held at 58368.
  - in_ready drops once the second last product is in s1.
  - Raising out_ready delivers 58368, 1024, 1024 in order with no loss or duplication.
- ACC_W=16, cfg_len=2, two (255,255) pairs -> out_sum=65535, out_ovf=1. The next group, (8,128) with cfg_len=1, gives 1024 with out_ovf=0.
- Reset asserted after 2 of 3 terms, and again with a result pending -> out_valid=0, out_sum=0, in_ready=1. A following group of 1 (8,128) -> 1024.

Source files
------------

// File: rtl/bam8_mac_acc_if.sv
`default_nettype none
// ============================================================================
// Module   : bam8_mac_acc_if
// Purpose  : Operand/result handshake bundle for the BAM 8x8 MAC accumulator.
// Revision : 1.0
// ============================================================================
interface bam8_mac_acc_if #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
);
    logic [CNT_W-1:0] cfg_len;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;

    modport master (
        output cfg_len, in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  cfg_len, in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/bam8_mac_acc.sv
`default_nettype none
// ============================================================================
// Module   : bam8_mac_acc
// Purpose  : Registered BAM (hbl=1, vbl=10) product stage feeding a saturating
//            grouped accumulator with valid/ready on both sides.
// Revision : 1.0
// ============================================================================
module bam8_mac_acc #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    bam8_mac_acc_if.slave  bus
);

    logic [15:0]      w_prod;
    logic [CNT_W-1:0] w_len_cfg;
    logic [CNT_W-1:0] w_len_eff;
    logic             w_last;
    logic             w_s1_adv;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_fire;
    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_sat;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [15:0]      s1_p_q, s1_p_d;
    logic             s1_vld_q, s1_vld_d;
    logic             s1_last_q, s1_last_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_valid_q, out_valid_d;

    // Only partial products with i+j >= 10 survive, which needs i,j >= 3.
    always_comb begin
        w_prod = '0;
        for (int i = 3; i < 8; i++) begin
            for (int j = 10 - i; j < 8; j++) begin
                w_prod = w_prod + (16'(bus.in_a[i] & bus.in_b[j]) << (i + j));
            end
        end
    end

    always_comb begin
        w_len_cfg  = (bus.cfg_len == '0) ? CNT_W'(1) : bus.cfg_len;
        w_len_eff  = (cnt_q == '0) ? w_len_cfg : len_q;
        w_last     = (cnt_q == (w_len_eff - CNT_W'(1)));
        // Only a last product waiting on an unaccepted result blocks stage 1.
        w_s1_adv   = !(s1_last_q && out_valid_q && !bus.out_ready);
        w_in_ready = !s1_vld_q || w_s1_adv;
        w_accept   = bus.in_valid && w_in_ready;
        w_fire     = s1_vld_q && w_s1_adv;
        w_sum      = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, s1_p_q};
        w_carry    = w_sum[ACC_W];
        w_sat      = w_carry ? '1 : w_sum[ACC_W-1:0];
    end

    always_comb begin
        cnt_d       = cnt_q;
        len_d       = len_q;
        s1_p_d      = s1_p_q;
        s1_vld_d    = s1_vld_q;
        s1_last_d   = s1_last_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q && !bus.out_ready;

        if (w_accept) begin
            if (cnt_q == '0) begin
                len_d = w_len_cfg;
            end
            cnt_d     = w_last ? '0 : cnt_q + CNT_W'(1);
            s1_p_d    = w_prod;
            s1_vld_d  = 1'b1;
            s1_last_d = w_last;
        end else if (w_s1_adv) begin
            s1_vld_d = 1'b0;
        end

        if (w_fire) begin
            if (s1_last_q) begin
                out_sum_d   = w_sat;
                out_ovf_d   = ovf_q | w_carry;
                out_valid_d = 1'b1;
                acc_d       = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_d = w_sat;
                ovf_d = ovf_q | w_carry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            len_q       <= CNT_W'(1);
            s1_p_q      <= '0;
            s1_vld_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            s1_p_q      <= s1_p_d;
            s1_vld_q    <= s1_vld_d;
            s1_last_q   <= s1_last_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule
`default_nettype wire
